mccu_quota_engine: RTL

//  Parametrised successor to the MCCU: per-core contention-quota budgets.
//  - Each cycle, weighted event counts are summed per core and subtracted from that core's quota.
//  - Subtraction saturates at zero.
//  - A sticky per-core interrupt is raised on exhaustion.
//  - Adds: per-core enable, per-core quota reload, interrupt clear, a 2-stage pipeline and a per-core state machine.
//  - Sits between the PMU event bus and the interrupt controller; configured over the SoC register bank.

---
 rtl/mccu_pkg.sv | 16 +
 rtl/mccu_core_slice.sv | 124 ++++++++++++
 rtl/mccu_quota_engine.sv | 47 ++++
 3 files changed

// File: rtl/mccu_pkg.sv
// Shared types and helpers for the MCCU quota engine: per-core FSM encoding
// and the width of the per-core weighted event sum.
package mccu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EXH  = 2'd2
    } mccu_state_e;

    // Sum of CORE_EVENTS weights never exceeds this many bits.
    function automatic int sum_width(input int weights_width, input int core_events);
        return weights_width + $clog2(core_events + 1);
    endfunction

endpackage

// File: rtl/mccu_core_slice.sv
// One monitored core: weighted event adder, stage-1 sum register, saturating
// quota register, sticky exhaustion interrupt and the IDLE/RUN/EXH state machine.
module mccu_core_slice
    import mccu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int WEIGHTS_WIDTH = 8,
    parameter int CORE_EVENTS   = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 act_i,
    input  logic [CORE_EVENTS-1:0]               events_i,
    input  logic [CORE_EVENTS*WEIGHTS_WIDTH-1:0] weights_i,
    input  logic                                 quota_we_i,
    input  logic [DATA_WIDTH-1:0]                quota_i,
    input  logic                                 intr_clr_i,
    output logic [DATA_WIDTH-1:0]                quota_o,
    output logic                                 intr_o,
    output logic [1:0]                           state_o
);

    localparam int SW = sum_width(WEIGHTS_WIDTH, CORE_EVENTS);
    localparam int CW = (SW > DATA_WIDTH) ? SW : DATA_WIDTH;

    logic [SW-1:0]         sum_s;
    logic [SW-1:0]         sum_r;
    logic [DATA_WIDTH-1:0] quota_r;
    logic [DATA_WIDTH-1:0] quota_nxt_s;
    logic [CW-1:0]         sum_ext_s;
    logic [CW-1:0]         quota_ext_s;
    logic [CW-1:0]         diff_s;
    logic                  ge_s;
    logic                  set_s;
    logic                  intr_r;
    logic                  intr_nxt_s;
    mccu_state_e           state_r;
    mccu_state_e           state_nxt_s;

    // Weighted sum of this cycle's event pulses.
    always_comb begin
        sum_s = {SW{1'b0}};
        for (int e = 0; e < CORE_EVENTS; e++) begin
            if (events_i[e]) begin
                sum_s = sum_s + SW'(weights_i[e*WEIGHTS_WIDTH +: WEIGHTS_WIDTH]);
            end else begin
                sum_s = sum_s;
            end
        end
    end

    assign sum_ext_s   = CW'(sum_r);
    assign quota_ext_s = CW'(quota_r);
    assign diff_s      = quota_ext_s - sum_ext_s;
    assign ge_s        = (sum_ext_s >= quota_ext_s);
    // A reload drops the pending sum entirely, so it cannot raise the interrupt either.
    assign set_s       = act_i & (sum_r != {SW{1'b0}}) & ge_s & ~quota_we_i;

    // Next quota: reload wins, otherwise saturating subtract of the registered sum.
    always_comb begin
        quota_nxt_s = quota_r;
        if (quota_we_i) begin
            quota_nxt_s = quota_i;
        end else if (ge_s) begin
            quota_nxt_s = {DATA_WIDTH{1'b0}};
        end else begin
            quota_nxt_s = DATA_WIDTH'(diff_s);
        end
    end

    // Sticky interrupt: a set in the same cycle as a clear takes precedence.
    always_comb begin
        intr_nxt_s = intr_r;
        if (set_s) begin
            intr_nxt_s = 1'b1;
        end else if (intr_clr_i) begin
            intr_nxt_s = 1'b0;
        end else begin
            intr_nxt_s = intr_r;
        end
    end

    // Per-core state machine next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (act_i) state_nxt_s = RUN;
                else       state_nxt_s = IDLE;
            end
            RUN: begin
                if (!act_i)     state_nxt_s = IDLE;
                else if (set_s) state_nxt_s = EXH;
                else            state_nxt_s = RUN;
            end
            EXH: begin
                if (!act_i)                                            state_nxt_s = IDLE;
                else if (quota_we_i && (quota_i != {DATA_WIDTH{1'b0}})) state_nxt_s = RUN;
                else                                                   state_nxt_s = EXH;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Pipeline, quota, interrupt and state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_r   <= {SW{1'b0}};
            quota_r <= {DATA_WIDTH{1'b0}};
            intr_r  <= 1'b0;
            state_r <= IDLE;
        end else begin
            sum_r   <= act_i ? sum_s : {SW{1'b0}};
            quota_r <= quota_nxt_s;
            intr_r  <= intr_nxt_s;
            state_r <= state_nxt_s;
        end
    end

    assign quota_o = quota_r;
    assign intr_o  = intr_r;
    assign state_o = state_r;

endmodule

// File: rtl/mccu_quota_engine.sv
// Per-core contention-quota engine: one mccu_core_slice per core, with the
// flat PMU/register-bank buses split into per-core slices.
module mccu_quota_engine
    import mccu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int WEIGHTS_WIDTH = 8,
    parameter int N_CORES       = 4,
    parameter int CORE_EVENTS   = 4
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         enable_i,
    input  logic [N_CORES-1:0]                           core_en_i,
    input  logic [N_CORES*CORE_EVENTS-1:0]               events_i,
    input  logic [N_CORES*CORE_EVENTS*WEIGHTS_WIDTH-1:0] weights_i,
    input  logic [N_CORES-1:0]                           quota_we_i,
    input  logic [N_CORES*DATA_WIDTH-1:0]                quota_i,
    input  logic [N_CORES-1:0]                           intr_clr_i,
    output logic [N_CORES*DATA_WIDTH-1:0]                quota_o,
    output logic [N_CORES-1:0]                           intr_o,
    output logic [N_CORES*2-1:0]                         state_o
);

    localparam int WPC = CORE_EVENTS * WEIGHTS_WIDTH;

    for (genvar c = 0; c < N_CORES; c++) begin : g_core
        mccu_core_slice #(
            .DATA_WIDTH    (DATA_WIDTH),
            .WEIGHTS_WIDTH (WEIGHTS_WIDTH),
            .CORE_EVENTS   (CORE_EVENTS)
        ) u_slice (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .act_i      (enable_i & core_en_i[c]),
            .events_i   (events_i[c*CORE_EVENTS +: CORE_EVENTS]),
            .weights_i  (weights_i[c*WPC +: WPC]),
            .quota_we_i (quota_we_i[c]),
            .quota_i    (quota_i[c*DATA_WIDTH +: DATA_WIDTH]),
            .intr_clr_i (intr_clr_i[c]),
            .quota_o    (quota_o[c*DATA_WIDTH +: DATA_WIDTH]),
            .intr_o     (intr_o[c]),
            .state_o    (state_o[c*2 +: 2])
        );
    end

endmodule
